reg_bank_p: RTL and testbench

Parametrised instruction-driven register bank: `COUNT` registers of `WIDTH` bits, written through a single opcode/index/immediate instruction port and exposed both as a flat parallel output bus and through a registered read port. It is the generic successor of the fixed 8x8 load-only bank, adding per-register increment, decrement and clear, a multi-cycle clear-all sweep, and explicit ready/error status. It sits between the instruction sequencer and any consumer of static configuration bytes.

---
 rtl/reg_bank_pkg.sv | 33 +++
 rtl/reg_bank_p_if.sv | 37 +++
 rtl/reg_bank_p.sv | 122 ++++++++++++
 tb/tb_reg_bank_p.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// ============================================================================
// Module   : reg_bank_pkg
// Brief    : Opcodes, bank states and width helper shared by the register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_bank_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_LD     = 4'd1,
        OP_INC    = 4'd2,
        OP_DEC    = 4'd3,
        OP_CLR    = 4'd4,
        OP_CLRALL = 4'd5
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_CLEAR = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // Instruction word: opcode, index and immediate, packed from the top down.
    function automatic int inst_width(input int width, input int count);
        return 4 + $clog2(count) + width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_p_if.sv
// ============================================================================
// Module   : reg_bank_p_if
// Brief    : Instruction, read-port and status bundle of the register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reg_bank_p_if
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 8
);
    localparam int IDX_W  = $clog2(COUNT);
    localparam int INST_W = inst_width(WIDTH, COUNT);

    logic [INST_W-1:0]      inst;
    logic                   inst_en;
    logic [IDX_W-1:0]       rd_sel;
    logic [WIDTH-1:0]       rd_data;
    logic [COUNT*WIDTH-1:0] out;
    logic                   ready;
    logic                   error;

    modport master (
        output inst, inst_en, rd_sel,
        input  rd_data, out, ready, error
    );

    modport slave (
        input  inst, inst_en, rd_sel,
        output rd_data, out, ready, error
    );

endinterface

`default_nettype wire

// File: rtl/reg_bank_p.sv
// ============================================================================
// Module   : reg_bank_p
// Brief    : Instruction-driven COUNT x WIDTH register bank with sweep clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_bank_p
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 8
)(
    input  wire logic   clock,
    input  wire logic   reset,
    reg_bank_p_if.slave bus
);
    localparam int IDX_W  = $clog2(COUNT);
    localparam int CNT_W  = $clog2(COUNT + 1);
    localparam int INST_W = inst_width(WIDTH, COUNT);

    localparam logic [IDX_W:0]   C_COUNT = (IDX_W + 1)'(COUNT);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(COUNT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_regs [COUNT];
    logic [WIDTH-1:0] r_rd_data;

    logic [3:0]       w_op;
    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_imm;
    logic             w_idx_ok;
    logic             w_sel_ok;

    always_comb begin
        w_op     = bus.inst[INST_W-1 -: 4];
        w_idx    = bus.inst[WIDTH +: IDX_W];
        w_imm    = bus.inst[WIDTH-1:0];
        w_idx_ok = ({1'b0, w_idx} < C_COUNT);
        w_sel_ok = ({1'b0, bus.rd_sel} < C_COUNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RESET;
            r_cnt     <= '0;
            r_rd_data <= '0;
            for (int i = 0; i < COUNT; i++) r_regs[i] <= '0;
        end else begin
            // Read samples the pre-write contents of this same edge.
            r_rd_data <= w_sel_ok ? r_regs[bus.rd_sel] : '0;

            unique case (r_state)
                ST_RESET: r_state <= ST_READY;

                ST_READY: begin
                    if (bus.inst_en) begin
                        case (w_op)
                            OP_NOP: ;
                            OP_LD, OP_INC, OP_DEC, OP_CLR: begin
                                if (!w_idx_ok) begin
                                    r_state <= ST_ERROR;
                                    for (int i = 0; i < COUNT; i++) r_regs[i] <= '0;
                                end else begin
                                    case (w_op)
                                        OP_LD:   r_regs[w_idx] <= w_imm;
                                        OP_INC:  r_regs[w_idx] <= r_regs[w_idx] + WIDTH'(1);
                                        OP_DEC:  r_regs[w_idx] <= r_regs[w_idx] - WIDTH'(1);
                                        default: r_regs[w_idx] <= '0;
                                    endcase
                                end
                            end
                            OP_CLRALL: begin
                                r_state <= ST_CLEAR;
                                r_cnt   <= '0;
                            end
                            default: begin
                                r_state <= ST_ERROR;
                                for (int i = 0; i < COUNT; i++) r_regs[i] <= '0;
                            end
                        endcase
                    end
                end

                ST_CLEAR: begin
                    r_regs[r_cnt[IDX_W-1:0]] <= '0;
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_ERROR: begin
                    for (int i = 0; i < COUNT; i++) r_regs[i] <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < COUNT; gi++) begin : g_flat
        assign bus.out[gi*WIDTH +: WIDTH] = r_regs[gi];
    end

    assign bus.rd_data = r_rd_data;
    assign bus.ready   = (r_state == ST_READY);
    assign bus.error   = (r_state == ST_ERROR);

`ifdef SIM
    string dbg_state;
    string dbg_inst;
    always_comb begin
        dbg_state = r_state.name();
        dbg_inst  = $sformatf("op=%0d idx=%0d imm=%0h en=%0b", w_op, w_idx, w_imm, bus.inst_en);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_p.sv
// ============================================================================
// Module   : tb_reg_bank_p
// Brief    : Directed plus randomized checks of reg_bank_p against a bank model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bank_p;
    import reg_bank_pkg::*;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int N5 = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;

    reg_bank_p_if #(.WIDTH(W), .COUNT(N))  bus8 ();
    reg_bank_p_if #(.WIDTH(W), .COUNT(N5)) bus5 ();

    reg_bank_p #(.WIDTH(W), .COUNT(N))  dut  (.clock(clock), .reset(reset), .bus(bus8.slave));
    reg_bank_p #(.WIDTH(W), .COUNT(N5)) dut5 (.clock(clock), .reset(reset), .bus(bus5.slave));

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural bank: plain integer registers and a mode word.
    int m_reg [N];
    int m_mode;   // 0 reset, 1 ready, 2 sweeping, 3 error
    int m_pos;
    int m_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_out();
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(m_reg[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_reg[i] = 0;
        m_mode = 0;
        m_pos  = 0;
        m_rd   = 0;
    endtask

    task automatic model_error();
        m_mode = 3;
        for (int i = 0; i < N; i++) m_reg[i] = 0;
    endtask

    task automatic model_edge(input bit en, input int op, input int idx, input int imm, input int sel);
        int nrd;
        nrd = (sel < N) ? m_reg[sel] : 0;
        case (m_mode)
            0: m_mode = 1;
            1: if (en) begin
                if (op >= 1 && op <= 4) begin
                    if (idx >= N) model_error();
                    else case (op)
                        1: m_reg[idx] = imm;
                        2: m_reg[idx] = (m_reg[idx] + 1) % 256;
                        3: m_reg[idx] = (m_reg[idx] + 255) % 256;
                        default: m_reg[idx] = 0;
                    endcase
                end else if (op == 5) begin
                    m_mode = 2;
                    m_pos  = 0;
                end else if (op >= 6) begin
                    model_error();
                end
            end
            2: begin
                m_reg[m_pos] = 0;
                m_pos++;
                if (m_pos == N) m_mode = 1;
            end
            default: ;
        endcase
        m_rd = nrd;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/out"},   bus8.out,     m_out());
        check({tag, "/rd"},    bus8.rd_data, 64'(m_rd));
        check({tag, "/ready"}, bus8.ready,   64'(m_mode == 1));
        check({tag, "/error"}, bus8.error,   64'(m_mode == 3));
    endtask

    task automatic step(input string tag, input int op, input int idx, input int imm,
                        input bit en, input int sel);
        bus8.inst    = {4'(op), 3'(idx), 8'(imm)};
        bus8.inst_en = en;
        bus8.rd_sel  = 3'(sel);
        @(posedge clock);
        model_edge(en, op, idx, imm, sel);
        #1;
        check_all(tag);
    endtask

    initial begin
        int lows;
        bus8.inst = '0; bus8.inst_en = 1'b0; bus8.rd_sel = '0;
        bus5.inst = '0; bus5.inst_en = 1'b0; bus5.rd_sel = '0;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check_all("in_reset");

        reset = 1'b1;
        step("release", 0, 0, 0, 1'b0, 0);
        step("ld3", 1, 3, 8'hA5, 1'b1, 0);
        check("ld3_const", bus8.out, 64'h00000000_A5000000);

        // Wrap-around of increment and decrement.
        step("ld2", 1, 2, 8'hFF, 1'b1, 0);
        step("inc2", 2, 2, 0, 1'b1, 0);
        check("inc_wrap", 64'(bus8.out[23:16]), 64'h00);
        step("dec2", 3, 2, 0, 1'b1, 0);
        check("dec_wrap", 64'(bus8.out[23:16]), 64'hFF);
        step("sel2", 0, 0, 0, 1'b0, 2);
        step("sel2b", 0, 0, 0, 1'b0, 2);
        check("rd_after_dec", 64'(bus8.rd_data), 64'hFF);

        // Fill, then sweep with instructions still arriving.
        for (int i = 0; i < N; i++) step("fill", 1, i, (i + 1) * 8'h11, 1'b1, i);
        step("clrall", 5, 3, 8'h99, 1'b1, 0);
        lows = bus8.ready ? 0 : 1;
        for (int g = 0; g < 20 && !bus8.ready; g++) begin
            step("sweep", 1, 0, 8'h55, 1'b1, g % N);
            if (!bus8.ready) lows++;
        end
        check("clrall_busy_cycles", 64'(lows), 64'd8);
        check("clrall_zero", bus8.out, 64'h0);

        for (int k = 0; k < 150; k++) begin
            step("rand", $urandom_range(0, 5), $urandom_range(0, N - 1),
                 $urandom_range(0, 255), ($urandom_range(0, 3) != 0), $urandom_range(0, N - 1));
        end

        // Read and write of the same register on one edge.
        step("ld1_old", 1, 1, 8'h10, 1'b1, 0);
        step("ld1_new", 1, 1, 8'h20, 1'b1, 1);
        check("same_edge_old", 64'(bus8.rd_data), 64'h10);
        step("rd1_new", 0, 0, 0, 1'b0, 1);
        check("same_edge_new", 64'(bus8.rd_data), 64'h20);

        // Five-register bank: out-of-range read and index.
        bus5.inst = {4'd1, 3'd1, 8'h33}; bus5.inst_en = 1'b1; bus5.rd_sel = 3'd1;
        step("b5_ld", 0, 0, 0, 1'b0, 0);
        bus5.inst_en = 1'b0;
        step("b5_hold", 0, 0, 0, 1'b0, 0);
        check("b5_rd1", 64'(bus5.rd_data), 64'h33);
        check("b5_out", 64'(bus5.out), 64'h3300);
        bus5.rd_sel = 3'd6;
        step("b5_sel6", 0, 0, 0, 1'b0, 0);
        check("b5_rd_oob", 64'(bus5.rd_data), 64'h0);
        bus5.inst = {4'd1, 3'd6, 8'h77}; bus5.inst_en = 1'b1;
        step("b5_bad_idx", 0, 0, 0, 1'b0, 0);
        check("b5_error", 64'(bus5.error), 64'h1);
        check("b5_ready", 64'(bus5.ready), 64'h0);
        check("b5_zero", 64'(bus5.out), 64'h0);
        bus5.inst = {4'd1, 3'd0, 8'h44};
        step("b5_sticky", 0, 0, 0, 1'b0, 0);
        check("b5_sticky_out", 64'(bus5.out), 64'h0);
        check("b5_sticky_err", 64'(bus5.error), 64'h1);
        bus5.inst_en = 1'b0;

        // Illegal opcode, then asynchronous reset between edges.
        step("ld4", 1, 4, 8'h5A, 1'b1, 0);
        step("op_b", 4'hB, 0, 0, 1'b1, 0);
        step("err_ld", 1, 2, 8'h12, 1'b1, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("b5_async_err", 64'(bus5.error), 64'h0);
        #1;
        reset = 1'b1;
        step("after_rst", 0, 0, 0, 1'b0, 0);
        check("b5_after_rst", 64'(bus5.ready), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
